tx_scheduler: RTL and testbench
===============================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter DATA_W, 18, payload word width presented to the transmitter datapath.
REQ-002 Parameter FRAME_LEN, 8, payload words per frame (legal range 1..255).
REQ-003 Parameter AUDIO_RUN, 4, max consecutive audio frames granted while text waits (legal range 1..15).
REQ-004 Parameter PILOT_WORD, 18'd16, known attenuation-probe word sent at frame start.
REQ-005 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 AUD_DATA  in  DATA_W  modulated audio word; AUD_VALID  in  1; AUD_READY  out  1.
REQ-008 TXT_DATA  in  DATA_W  modulated text word; TXT_VALID  in  1; TXT_READY  out  1.
REQ-009 TX_DATA  out  DATA_W  word to transmitter; TX_VALID  out  1; TX_READY  in  1 downstream backpressure.
REQ-010 TX_MODE  out  1  0 = audio frame (3-bit pad path), 1 = text frame (18-bit pad path); constant for a whole frame.
REQ-011 TX_PILOT  out  1  high while TX_DATA holds the pilot word.
REQ-012 FRAME_DONE  out  1  one-cycle pulse on the cycle the last payload word of a frame transfers out.

Function
REQ-013 Transfer on any valid/ready pair occurs on a rising edge where VALID and READY are both high; VALID SHALL not be dropped by this block while its READY is low.
REQ-014 Output stage is a single register; it SHALL load when (!TX_VALID || TX_READY); TX_DATA/TX_MODE/TX_PILOT SHALL hold stable while TX_VALID && !TX_READY.
REQ-015 Latency: a word accepted from a source at edge N SHALL appear on TX_DATA with TX_VALID high after edge N (one cycle).
REQ-016 FSM states: IDLE, PILOT, PAYLOAD.
REQ-017 IDLE: if exactly one source valid, grant it; if both valid, grant audio unless run counter == AUDIO_RUN, then grant text; move to PILOT; no source READY asserted in IDLE.
REQ-018 PILOT: load PILOT_WORD with TX_PILOT=1 and TX_MODE=grant when output stage can load; then PAYLOAD; no source READY asserted.
REQ-019 PAYLOAD: only the granted source's READY = (!TX_VALID || TX_READY); the other READY SHALL be 0.
REQ-020 Payload counter increments per accepted word; after FRAME_LEN-th acceptance return to IDLE; frame never aborted, stalls indefinitely while granted source invalid.
REQ-021 FRAME_DONE pulses when the output stage's last payload word of the frame transfers out (TX_VALID && TX_READY), not on acceptance.
REQ-022 Run counter: +1 (saturating at AUDIO_RUN) on each audio grant made while TXT_VALID high; cleared on any text grant or on an audio grant with TXT_VALID low.
REQ-023 Back-to-back frames: IDLE SHALL last exactly one cycle when a source is valid; TX_MODE may change only on the pilot word.

Reset
REQ-024 RESET high SHALL immediately force state IDLE, payload counter 0, run counter 0, grant audio, TX_DATA 0, TX_VALID 0, TX_MODE 0, TX_PILOT 0, FRAME_DONE 0, AUD_READY 0, TXT_READY 0.
REQ-025 Reset mid-frame SHALL discard the partial frame and any held output word; first frame after release starts with a pilot.

Configuration
REQ-026 Macro TX_PILOT_EN defined: PILOT state and pilot insertion as above.
REQ-027 TX_PILOT_EN undefined: PILOT state absent, IDLE goes directly to PAYLOAD, TX_PILOT tied 0, first payload word carries the new TX_MODE; all else unchanged.

Verification
REQ-028 Audio only, AUD_VALID held, TX_READY=1, FRAME_LEN=8 -> repeating 9-word frames: 16 (TX_PILOT=1), then 8 audio words, TX_MODE=0, FRAME_DONE once per frame.
REQ-029 Both sources valid continuously, AUDIO_RUN=4 -> frame modes 0,0,0,0,1,0,0,0,0,1...
REQ-030 TX_READY low for 5 cycles mid-frame -> TX_DATA held constant, granted READY low, no word lost or duplicated (compare sequence numbers).
REQ-031 Text granted, TXT_VALID drops after 3 words for 10 cycles while AUD_VALID high -> AUD_READY stays 0, frame completes with 8 text words, then audio frame.
REQ-032 RESET asserted asynchronously mid-PAYLOAD -> all outputs 0 in same cycle; after release next output word is pilot 16.
REQ-033 Build without TX_PILOT_EN, rerun REQ-028 -> 8-word frames, no pilot, TX_PILOT always 0.

Source files
------------

// File: rtl/tx_scheduler.sv
// Frame scheduler: arbitrates audio/text word streams into pilot-led frames feeding one output register.
// Optional pilot insertion is enabled by defining TX_PILOT_EN.
module tx_scheduler #(
    parameter int                DATA_W     = 18,
    parameter int                FRAME_LEN  = 8,
    parameter int                AUDIO_RUN  = 4,
    parameter logic [DATA_W-1:0] PILOT_WORD = DATA_W'(16)
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [DATA_W-1:0] AUD_DATA,
    input  logic              AUD_VALID,
    output logic              AUD_READY,
    input  logic [DATA_W-1:0] TXT_DATA,
    input  logic              TXT_VALID,
    output logic              TXT_READY,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              TX_MODE,
    output logic              TX_PILOT,
    output logic              FRAME_DONE
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [3:0] RUN_MAX  = 4'(AUDIO_RUN);

`ifdef TX_PILOT_EN
    typedef enum logic [1:0] {IDLE, PILOT, PAYLOAD} state_t;
`else
    typedef enum logic [0:0] {IDLE, PAYLOAD} state_t;
`endif

    state_t            state_q, state_d;
    logic              grant_q, grant_d;      // 0 = audio, 1 = text
    logic [3:0]        run_q, run_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_mode_q, tx_mode_d;
    logic              tx_pilot_q, tx_pilot_d;
    logic              tx_last_q, tx_last_d;

    logic              load;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              pick_txt;
    logic              load_pilot;
    logic              load_word;
    logic              aud_ready;
    logic              txt_ready;

    assign load      = !tx_valid_q || TX_READY;
    assign src_valid = grant_q ? TXT_VALID : AUD_VALID;
    assign src_data  = grant_q ? TXT_DATA : AUD_DATA;
    assign pick_txt  = (AUD_VALID && TXT_VALID) ? (run_q == RUN_MAX) : TXT_VALID;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_mode_d  = tx_mode_q;
        tx_pilot_d = tx_pilot_q;
        tx_last_d  = tx_last_q;
        aud_ready  = 1'b0;
        txt_ready  = 1'b0;
        load_pilot = 1'b0;
        load_word  = 1'b0;

        // A free output slot with nothing new to load becomes a bubble.
        if (load) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (AUD_VALID || TXT_VALID) begin
                    grant_d = pick_txt;
                    if (pick_txt || !TXT_VALID) begin
                        run_d = '0;
                    end else if (run_q != RUN_MAX) begin
                        run_d = run_q + 1'b1;
                    end
`ifdef TX_PILOT_EN
                    state_d = PILOT;
`else
                    state_d = PAYLOAD;
`endif
                end
            end
`ifdef TX_PILOT_EN
            PILOT: begin
                if (load) begin
                    load_pilot = 1'b1;
                    state_d    = PAYLOAD;
                end
            end
`endif
            PAYLOAD: begin
                aud_ready = !grant_q && load;
                txt_ready = grant_q && load;
                if (load && src_valid) begin
                    load_word = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Mode only changes when a frame's first word is loaded, so it stays constant per frame.
        if (load_pilot || load_word) begin
            tx_valid_d = 1'b1;
            tx_data_d  = load_pilot ? PILOT_WORD : src_data;
            tx_mode_d  = grant_q;
            tx_pilot_d = load_pilot;
            tx_last_d  = load_word && (cnt_q == LAST_IDX);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            run_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_mode_q  <= 1'b0;
            tx_pilot_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_mode_q  <= tx_mode_d;
            tx_pilot_q <= tx_pilot_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign AUD_READY  = aud_ready;
    assign TXT_READY  = txt_ready;
    assign TX_DATA    = tx_data_q;
    assign TX_VALID   = tx_valid_q;
    assign TX_MODE    = tx_mode_q;
    assign TX_PILOT   = tx_pilot_q;
    assign FRAME_DONE = tx_valid_q && TX_READY && tx_last_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: scenario table, directed corner sequences and randomized traffic
// against a transaction-level scoreboard. Works with or without TX_PILOT_EN.
module tb_tx_scheduler;

    localparam int          DATA_W    = 18;
    localparam int          FRAME_LEN = 8;
    localparam int          AUDIO_RUN = 4;
    localparam logic [17:0] PILOT     = 18'd16;
`ifdef TX_PILOT_EN
    localparam int PIL = 1;
`else
    localparam int PIL = 0;
`endif

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic [DATA_W-1:0] AUD_DATA = '0;
    logic              AUD_VALID = 1'b0;
    logic              AUD_READY;
    logic [DATA_W-1:0] TXT_DATA = '0;
    logic              TXT_VALID = 1'b0;
    logic              TXT_READY;
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_READY = 1'b0;
    logic              TX_MODE;
    logic              TX_PILOT;
    logic              FRAME_DONE;

    tx_scheduler #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .AUDIO_RUN(AUDIO_RUN), .PILOT_WORD(PILOT)
    ) dut (
        .CLOCK_50(clk), .RESET(RESET),
        .AUD_DATA(AUD_DATA), .AUD_VALID(AUD_VALID), .AUD_READY(AUD_READY),
        .TXT_DATA(TXT_DATA), .TXT_VALID(TXT_VALID), .TXT_READY(TXT_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .TX_MODE(TX_MODE), .TX_PILOT(TX_PILOT), .FRAME_DONE(FRAME_DONE)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted words in order, frame sources in grant order, spec arbitration rules.
    logic [17:0] acc_q[$];
    bit          fsrc_q[$];
    bit          mode_log[$];
    int          fd_cnt = 0;
    bit          idle_m = 1'b1;
    bit          in_src = 1'b0;
    int          in_cnt = 0;
    int          run_m = 0;
    int          out_pos = 0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_data;
    bit          prev_mode, prev_pilot;

    always @(negedge clk) begin : mon
        bit s;
        if (RESET) begin
            acc_q.delete(); fsrc_q.delete(); mode_log.delete();
            fd_cnt = 0; idle_m = 1'b1; run_m = 0; out_pos = 0; in_cnt = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", TX_VALID, 1);
                chk("hold_data", TX_DATA, prev_data);
                chk("hold_mode", TX_MODE, prev_mode);
                chk("hold_pilot", TX_PILOT, prev_pilot);
            end
            prev_stall = TX_VALID && !TX_READY;
            prev_data  = TX_DATA;
            prev_mode  = TX_MODE;
            prev_pilot = TX_PILOT;

            if (idle_m) begin
                chk("idle_ready", {AUD_READY, TXT_READY}, 0);
                if (AUD_VALID || TXT_VALID) begin
                    if (AUD_VALID && TXT_VALID) s = (run_m == AUDIO_RUN);
                    else s = TXT_VALID;
                    if (s || !TXT_VALID) run_m = 0;
                    else if (run_m < AUDIO_RUN) run_m++;
                    fsrc_q.push_back(s);
                    in_src = s; in_cnt = 0; idle_m = 1'b0;
                end
            end else begin
                chk("other_ready", in_src ? AUD_READY : TXT_READY, 0);
                if ((AUD_VALID && AUD_READY) || (TXT_VALID && TXT_READY)) begin
                    acc_q.push_back(in_src ? TXT_DATA : AUD_DATA);
                    in_cnt++;
                    if (in_cnt == FRAME_LEN) idle_m = 1'b1;
                end
            end

            if (TX_VALID && TX_READY) begin
                if (fsrc_q.size() == 0) begin
                    chk("out_frame_known", 0, 1);
                end else begin
                    s = fsrc_q[0];
                    if (out_pos == 0) mode_log.push_back(TX_MODE);
                    chk("out_mode", TX_MODE, s);
                    if (out_pos < PIL) begin
                        chk("pilot_data", TX_DATA, PILOT);
                        chk("pilot_flag", TX_PILOT, 1);
                        chk("pilot_frame_done", FRAME_DONE, 0);
                    end else begin
                        if (acc_q.size() == 0) chk("out_word_exists", 0, 1);
                        else chk("out_word", TX_DATA, acc_q.pop_front());
                        chk("payload_pilot_flag", TX_PILOT, 0);
                        chk("frame_done", FRAME_DONE, out_pos == FRAME_LEN + PIL - 1);
                    end
                    out_pos++;
                    if (out_pos == FRAME_LEN + PIL) begin
                        out_pos = 0;
                        void'(fsrc_q.pop_front());
                    end
                    if (FRAME_DONE) fd_cnt++;
                end
            end else begin
                chk("frame_done_no_xfer", FRAME_DONE, 0);
            end
        end
    end

    // Source/sink driver: valid is held until accepted, then re-rolled.
    int aud_p = 0, txt_p = 0, rdy_p = 100;
    int aud_seq = 0, txt_seq = 0, aud_acc_cnt = 0, txt_acc_cnt = 0;

    task automatic roll_inputs();
        AUD_DATA = {2'b10, aud_seq[15:0]};
        TXT_DATA = {2'b11, txt_seq[15:0]};
        TX_READY = (int'($urandom_range(0, 99)) < rdy_p);
    endtask

    task automatic step();
        bit a, t;
        @(negedge clk);
        a = AUD_VALID && AUD_READY;
        t = TXT_VALID && TXT_READY;
        @(posedge clk);
        #1;
        if (a) begin
            aud_seq++; aud_acc_cnt++;
            AUD_VALID = (int'($urandom_range(0, 99)) < aud_p);
        end else if (!AUD_VALID) begin
            AUD_VALID = (int'($urandom_range(0, 99)) < aud_p);
        end
        if (t) begin
            txt_seq++; txt_acc_cnt++;
            TXT_VALID = (int'($urandom_range(0, 99)) < txt_p);
        end else if (!TXT_VALID) begin
            TXT_VALID = (int'($urandom_range(0, 99)) < txt_p);
        end
        roll_inputs();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        AUD_VALID = (int'($urandom_range(0, 99)) < aud_p);
        TXT_VALID = (int'($urandom_range(0, 99)) < txt_p);
        roll_inputs();
        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (fd_cnt < n && k < budget) begin
            step();
            k++;
        end
        chk(name, fd_cnt >= n, 1);
    endtask

    task automatic wait_acc(input bit txt, input int target, input string name);
        int k = 0;
        while (((txt ? txt_acc_cnt : aud_acc_cnt) < target) && k < 200) begin
            step();
            k++;
        end
        chk(name, (txt ? txt_acc_cnt : aud_acc_cnt) >= target, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, TX_VALID, 0);
        chk({tag, "_tx_data"}, TX_DATA, 0);
        chk({tag, "_tx_mode"}, TX_MODE, 0);
        chk({tag, "_tx_pilot"}, TX_PILOT, 0);
        chk({tag, "_frame_done"}, FRAME_DONE, 0);
        chk({tag, "_aud_ready"}, AUD_READY, 0);
        chk({tag, "_txt_ready"}, TXT_READY, 0);
    endtask

    typedef struct {
        int         aud_p;
        int         txt_p;
        int         rdy_p;
        int         nfr;
        logic [9:0] modes;   // bit i = expected TX_MODE of frame i
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int base;
        logic [17:0] held, exp_first;

        tbl[0] = '{100,   0, 100,  3, 10'b0000000000};
        tbl[1] = '{  0, 100, 100,  3, 10'b0000000111};
        tbl[2] = '{100, 100, 100, 10, 10'b1000010000};
        tbl[3] = '{100, 100,  50, 10, 10'b1000010000};
        tbl[4] = '{  0, 100,  40,  2, 10'b0000000011};

        #5;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        check_outputs_zero("reset_after_edge");

        for (int i = 0; i < 5; i++) begin
            aud_p = tbl[i].aud_p; txt_p = tbl[i].txt_p; rdy_p = tbl[i].rdy_p;
            do_reset();
            wait_frames(tbl[i].nfr, 60 * tbl[i].nfr, $sformatf("tbl%0d_frames", i));
            chk($sformatf("tbl%0d_frames_logged", i), mode_log.size() >= tbl[i].nfr, 1);
            for (int j = 0; j < tbl[i].nfr; j++) begin
                if (j < mode_log.size())
                    chk($sformatf("tbl%0d_mode%0d", i, j), mode_log[j], tbl[i].modes[j]);
            end
        end

        // Output stall mid-frame: word held, granted source throttled.
        aud_p = 100; txt_p = 0; rdy_p = 100;
        do_reset();
        wait_acc(1'b0, aud_acc_cnt + 3, "stall_reach_mid");
        rdy_p = 0;
        step();
        held = TX_DATA;
        chk("stall_valid", TX_VALID, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_data_held", TX_DATA, held);
            chk("stall_aud_ready", AUD_READY, 0);
        end
        rdy_p = 100;
        wait_frames(2, 100, "stall_frames");

        // Text source stalls inside its frame while audio waits.
        aud_p = 0; txt_p = 100; rdy_p = 100;
        do_reset();
        base = txt_acc_cnt;
        step();
        aud_p = 100;
        wait_acc(1'b1, base + 2, "gap_two_words");
        txt_p = 0;
        wait_acc(1'b1, base + 3, "gap_three_words");
        for (int k = 0; k < 10; k++) begin
            step();
            chk("gap_aud_ready", AUD_READY, 0);
            chk("gap_txt_valid_low", TXT_VALID, 0);
        end
        txt_p = 100;
        wait_frames(2, 100, "gap_frames");
        chk("gap_txt_words", txt_acc_cnt - base, 8);
        if (mode_log.size() >= 2) begin
            chk("gap_mode0", mode_log[0], 1);
            chk("gap_mode1", mode_log[1], 0);
        end else begin
            chk("gap_modes_logged", mode_log.size(), 2);
        end

        // Asynchronous reset in the middle of a text payload.
        aud_p = 0; txt_p = 100; rdy_p = 100;
        do_reset();
        wait_acc(1'b1, txt_acc_cnt + 3, "arst_reach_mid");
        chk("arst_pre_valid", TX_VALID, 1);
        chk("arst_pre_mode", TX_MODE, 1);
        #4;
        RESET = 1'b1;
        #1;
        check_outputs_zero("arst");
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0;
        exp_first = (PIL != 0) ? PILOT : {2'b11, txt_seq[15:0]};
        step();
        step();
        chk("arst_first_valid", TX_VALID, 1);
        chk("arst_first_pilot", TX_PILOT, PIL);
        chk("arst_first_data", TX_DATA, exp_first);
        wait_frames(1, 100, "arst_frames");

        // Randomized traffic segments.
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin aud_p = 50;  txt_p = 50;  rdy_p = 70;  end
                1: begin aud_p = 90;  txt_p = 90;  rdy_p = 30;  end
                2: begin aud_p = 30;  txt_p = 80;  rdy_p = 100; end
                default: begin aud_p = 100; txt_p = 100; rdy_p = 50; end
            endcase
            do_reset();
            for (int k = 0; k < 1500; k++) step();
            chk($sformatf("rand%0d_progress", seg), fd_cnt > 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
